// File: rtl/snoop_mem_responder_pkg.sv
// Shared encodings for the snooping-cache memory responder: bus request codes,
// default bus widths and responder state encoding.
package snoop_mem_responder_pkg;

    localparam int unsigned IOSTATEWIDTH  = 2;
    localparam int unsigned ADDRWIDTH_DEF = 16;
    localparam int unsigned WORDWIDTH_DEF = 16;

    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd2;
    localparam logic [IOSTATEWIDTH-1:0] ILL  = 2'd3;

    localparam int unsigned STATEWIDTH = 2;
    localparam logic [STATEWIDTH-1:0] ST_IDLE = 2'd0;
    localparam logic [STATEWIDTH-1:0] ST_BUSY = 2'd1;
    localparam logic [STATEWIDTH-1:0] ST_RESP = 2'd2;

    // Only RD and WT start an access; IDEL and the illegal code do not.
    function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] code);
        return (code == RD) || (code == WT);
    endfunction

endpackage

// File: rtl/snoop_mem_responder_rr_arbiter2.sv
// Two-port round-robin arbiter. With MEM_WB_PRIORITY_EN defined, write requests
// (wb) win over reads and round-robin only breaks ties of the same type.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic [1:0] wb,
    input  logic       ptr,
    output logic       gnt_vld_c,
    output logic       gnt_c,
    output logic       ptr_nxt_c
);

    logic [1:0] cand;

`ifdef MEM_WB_PRIORITY_EN
    always_comb begin
        cand = req;
        if ((req & wb) != 2'b00) begin
            cand = req & wb;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^wb;
    assign cand      = req;
`endif

    // ptr names the preferred port when both candidates are present.
    always_comb begin
        gnt_vld_c = |cand;
        gnt_c     = 1'b0;
        ptr_nxt_c = ptr;
        if (cand == 2'b11) begin
            gnt_c = ptr;
        end else begin
            gnt_c = cand[1];
        end
        if (gnt_vld_c) begin
            ptr_nxt_c = ~gnt_c;
        end
    end

endmodule

// File: rtl/snoop_mem_responder.sv
// Main-memory responder for two snooping MSI caches: arbitrates RD/WT requests,
// serves them from a word array after LATENCY cycles. Option: MEM_WB_PRIORITY_EN.
module snoop_mem_responder
    import snoop_mem_responder_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int unsigned WORDWIDTH = WORDWIDTH_DEF,
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] memRW0,
    input  logic [ADDRWIDTH-1:0]    addrToMem0,
    input  logic [WORDWIDTH-1:0]    dataToMem0,
    input  logic [IOSTATEWIDTH-1:0] memRW1,
    input  logic [ADDRWIDTH-1:0]    addrToMem1,
    input  logic [WORDWIDTH-1:0]    dataToMem1,
    output logic [WORDWIDTH-1:0]    dataFromMem0,
    output logic [WORDWIDTH-1:0]    dataFromMem1,
    output logic [ADDRWIDTH-1:0]    addrFromMem0,
    output logic [ADDRWIDTH-1:0]    addrFromMem1,
    output logic                    memReadEn0,
    output logic                    memReadEn1,
    output logic                    memWriteDone0,
    output logic                    memWriteDone1,
    output logic                    busy,
    output logic                    havErr
);

    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [STATEWIDTH-1:0] state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  ptr, ptr_nxt;
    logic                  gnt_port, gnt_port_nxt;
    logic                  lat_wt, lat_wt_nxt;
    logic [ADDRWIDTH-1:0]  lat_addr, lat_addr_nxt;
    logic [WORDWIDTH-1:0]  lat_data, lat_data_nxt;

    logic [WORDWIDTH-1:0]  data0_nxt, data1_nxt;
    logic [ADDRWIDTH-1:0]  addr0_nxt, addr1_nxt;
    logic [1:0]            read_en, read_en_nxt;
    logic [1:0]            write_done, write_done_nxt;
    logic                  busy_nxt, err_nxt;

    logic [WORDWIDTH-1:0]  mem [0:DEPTH-1];
    logic [MEM_AW-1:0]     mem_idx_c;
    logic [WORDWIDTH-1:0]  mem_rd_c;
    logic                  mem_we_c;

    logic [1:0]            req_c, wb_c;
    logic                  illegal_c;
    logic                  gnt_vld_c, gnt_c, arb_ptr_c;

    // Illegal codes only raise the error flag and never request.
    assign req_c     = {is_req(memRW1), is_req(memRW0)};
    assign wb_c      = {memRW1 == WT, memRW0 == WT};
    assign illegal_c = (memRW0 == ILL) || (memRW1 == ILL);

    rr_arbiter2 u_arb (
        .req       (req_c),
        .wb        (wb_c),
        .ptr       (ptr),
        .gnt_vld_c (gnt_vld_c),
        .gnt_c     (gnt_c),
        .ptr_nxt_c (arb_ptr_c)
    );

    // Upper address bits alias onto the implemented array.
    assign mem_idx_c = lat_addr[MEM_AW-1:0];
    assign mem_rd_c  = mem[mem_idx_c];

    // Array is not cleared by reset; a write landing with reset high is dropped.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            mem[mem_idx_c] <= lat_data;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ptr_nxt        = ptr;
        gnt_port_nxt   = gnt_port;
        lat_wt_nxt     = lat_wt;
        lat_addr_nxt   = lat_addr;
        lat_data_nxt   = lat_data;
        data0_nxt      = dataFromMem0;
        data1_nxt      = dataFromMem1;
        addr0_nxt      = addrFromMem0;
        addr1_nxt      = addrFromMem1;
        read_en_nxt    = 2'b00;
        write_done_nxt = 2'b00;
        busy_nxt       = busy;
        err_nxt        = havErr | illegal_c;
        mem_we_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    state_nxt    = ST_BUSY;
                    cnt_nxt      = CNT_W'(LATENCY - 1);
                    ptr_nxt      = arb_ptr_c;
                    gnt_port_nxt = gnt_c;
                    lat_wt_nxt   = gnt_c ? (memRW1 == WT) : (memRW0 == WT);
                    lat_addr_nxt = gnt_c ? addrToMem1 : addrToMem0;
                    lat_data_nxt = gnt_c ? dataToMem1 : dataToMem0;
                    busy_nxt     = 1'b1;
                end
            end
            ST_BUSY: begin
                // The edge leaving BUSY commits the write or captures the read.
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    if (lat_wt) begin
                        mem_we_c                 = 1'b1;
                        write_done_nxt[gnt_port] = 1'b1;
                    end else begin
                        read_en_nxt[gnt_port] = 1'b1;
                        if (gnt_port) begin
                            data1_nxt = mem_rd_c;
                        end else begin
                            data0_nxt = mem_rd_c;
                        end
                    end
                    if (gnt_port) begin
                        addr1_nxt = lat_addr;
                    end else begin
                        addr0_nxt = lat_addr;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= 1'b0;
            gnt_port     <= 1'b0;
            lat_wt       <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            dataFromMem0 <= '0;
            dataFromMem1 <= '0;
            addrFromMem0 <= '0;
            addrFromMem1 <= '0;
            read_en      <= 2'b00;
            write_done   <= 2'b00;
            busy         <= 1'b0;
            havErr       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ptr          <= ptr_nxt;
            gnt_port     <= gnt_port_nxt;
            lat_wt       <= lat_wt_nxt;
            lat_addr     <= lat_addr_nxt;
            lat_data     <= lat_data_nxt;
            dataFromMem0 <= data0_nxt;
            dataFromMem1 <= data1_nxt;
            addrFromMem0 <= addr0_nxt;
            addrFromMem1 <= addr1_nxt;
            read_en      <= read_en_nxt;
            write_done   <= write_done_nxt;
            busy         <= busy_nxt;
            havErr       <= err_nxt;
        end
    end

    assign memReadEn0    = read_en[0];
    assign memReadEn1    = read_en[1];
    assign memWriteDone0 = write_done[0];
    assign memWriteDone1 = write_done[1];

endmodule

// File: tb/tb_snoop_mem_responder.sv
// Self-checking bench for snoop_mem_responder: directed scenarios plus random
// traffic checked against a transaction-level model of arbitration and memory.
module tb_snoop_mem_responder;

    localparam int L = 3;
    localparam logic [1:0] C_RD   = 2'd0;
    localparam logic [1:0] C_WT   = 2'd1;
    localparam logic [1:0] C_IDEL = 2'd2;
    localparam logic [1:0] C_ILL  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memRW0, memRW1;
    logic [15:0] addrToMem0, addrToMem1, dataToMem0, dataToMem1;
    logic [15:0] dataFromMem0, dataFromMem1, addrFromMem0, addrFromMem1;
    logic        memReadEn0, memReadEn1, memWriteDone0, memWriteDone1;
    logic        busy, havErr;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_mem [int];
    bit          ptr_m;
    bit          err_m;
    logic [15:0] obs_rd;

    snoop_mem_responder #(
        .ADDRWIDTH (16),
        .WORDWIDTH (16),
        .MEM_AW    (8),
        .LATENCY   (L)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memRW0        (memRW0),
        .addrToMem0    (addrToMem0),
        .dataToMem0    (dataToMem0),
        .memRW1        (memRW1),
        .addrToMem1    (addrToMem1),
        .dataToMem1    (dataToMem1),
        .dataFromMem0  (dataFromMem0),
        .dataFromMem1  (dataFromMem1),
        .addrFromMem0  (addrFromMem0),
        .addrFromMem1  (addrFromMem1),
        .memReadEn0    (memReadEn0),
        .memReadEn1    (memReadEn1),
        .memWriteDone0 (memWriteDone0),
        .memWriteDone1 (memWriteDone1),
        .busy          (busy),
        .havErr        (havErr)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        memRW0 = C_IDEL;
        memRW1 = C_IDEL;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ptr_m = 1'b0;
        err_m = 1'b0;
    endtask

    // Present requests on both ports (non-RD/WT = no request), each cache holding
    // its request until it sees its own response pulse, and check every cycle.
    task automatic serve(input logic [1:0] rw0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic [1:0] rw1, input logic [15:0] a1, input logic [15:0] d1,
                         input bit wdraw);
        logic [1:0]  prw [2];
        logic [15:0] pa [2];
        logic [15:0] pd [2];
        bit          r0, r1, exp_busy;
        int          n, first, second, t1, t2, kmax, p, key;
        logic [1:0]  re, wd;
        logic [5:0]  exp_v, obs_v;
        logic [15:0] oa, od;
        prw[0] = rw0; pa[0] = a0; pd[0] = d0;
        prw[1] = rw1; pa[1] = a1; pd[1] = d1;
        r0 = (rw0 == C_RD) || (rw0 == C_WT);
        r1 = (rw1 == C_RD) || (rw1 == C_WT);
        n  = int'(r0) + int'(r1);
        if (r0 && r1) begin
            first = int'(ptr_m);
`ifdef MEM_WB_PRIORITY_EN
            if (rw0 == C_WT && rw1 == C_RD) first = 0;
            else if (rw1 == C_WT && rw0 == C_RD) first = 1;
`endif
        end else begin
            first = r1 ? 1 : 0;
        end
        second = 1 - first;
        if (n >= 1) ptr_m = (first == 0);
        if (n == 2) ptr_m = (second == 0);
        t1   = 1 + L;
        t2   = 2 * L + 3;
        kmax = (n == 2) ? t2 + 1 : t1 + 1;

        @(posedge clk); #1;
        memRW0 = rw0; addrToMem0 = a0; dataToMem0 = d0;
        memRW1 = rw1; addrToMem1 = a1; dataToMem1 = d1;
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            exp_busy = (n >= 1 && k >= 1 && k <= t1) || (n == 2 && k >= t1 + 2 && k <= t2);
            re = 2'b00;
            wd = 2'b00;
            p  = -1;
            if (n >= 1 && k == t1) p = first;
            else if (n == 2 && k == t2) p = second;
            if (p >= 0) begin
                if (prw[p] == C_WT) wd[p] = 1'b1;
                else re[p] = 1'b1;
            end
            exp_v = {exp_busy, err_m, re[0], re[1], wd[0], wd[1]};
            obs_v = {busy, havErr, memReadEn0, memReadEn1, memWriteDone0, memWriteDone1};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL serve_flags k=%0d {busy,err,re0,re1,wd0,wd1} got %b expected %b",
                         k, obs_v, exp_v);
            end
            if (p >= 0) begin
                oa = (p == 0) ? addrFromMem0 : addrFromMem1;
                od = (p == 0) ? dataFromMem0 : dataFromMem1;
                n_tests++;
                if (oa !== pa[p]) begin
                    n_fail++;
                    $display("FAIL serve_addr port%0d got %h expected %h", p, oa, pa[p]);
                end
                key = int'(pa[p][7:0]);
                if (prw[p] == C_WT) begin
                    model_mem[key] = pd[p];
                end else begin
                    obs_rd = od;
                    if (model_mem.exists(key)) begin
                        n_tests++;
                        if (od !== model_mem[key]) begin
                            n_fail++;
                            $display("FAIL serve_rdata port%0d addr %h got %h expected %h",
                                     p, pa[p], od, model_mem[key]);
                        end
                    end
                end
            end
            @(posedge clk); #1;
            if (n >= 1 && ((wdraw && k == 0) || k == t1)) begin
                if (first == 0) memRW0 = C_IDEL; else memRW1 = C_IDEL;
            end
            if (n == 2 && k == t2) begin
                if (second == 0) memRW0 = C_IDEL; else memRW1 = C_IDEL;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        memRW0 = C_IDEL; memRW1 = C_IDEL;
        addrToMem0 = '0; addrToMem1 = '0; dataToMem0 = '0; dataToMem1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({dataFromMem0, dataFromMem1, addrFromMem0, addrFromMem1, memReadEn0, memReadEn1,
             memWriteDone0, memWriteDone1, busy, havErr} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b err=%b d0=%h d1=%h a0=%h a1=%h expected all zero",
                     busy, havErr, dataFromMem0, dataFromMem1, addrFromMem0, addrFromMem1);
        end
        @(posedge clk); #1 reset = 1'b0;
        ptr_m = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic test_write_read();
        serve(C_WT, 16'h0012, 16'hBEEF, C_IDEL, 16'h0, 16'h0, 1'b0);
        serve(C_RD, 16'h0012, 16'h0000, C_IDEL, 16'h0, 16'h0, 1'b0);
        n_tests++;
        if (obs_rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_read got %h expected beef", obs_rd);
        end
    endtask

    task automatic test_both_rd();
        do_reset();
        serve(C_RD, 16'h0012, 16'h0, C_RD, 16'h0012, 16'h0, 1'b0);
    endtask

    task automatic test_rd_vs_wt();
        logic [15:0] exp_rd;
        do_reset();
        serve(C_IDEL, 16'h0, 16'h0, C_WT, 16'h0020, 16'h7777, 1'b0);
        serve(C_RD, 16'h0020, 16'h0, C_WT, 16'h0020, 16'h8888, 1'b0);
`ifdef MEM_WB_PRIORITY_EN
        exp_rd = 16'h8888;
`else
        exp_rd = 16'h7777;
`endif
        n_tests++;
        if (obs_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL rd_vs_wt_order got %h expected %h", obs_rd, exp_rd);
        end
    endtask

    task automatic test_alias();
        serve(C_IDEL, 16'h0, 16'h0, C_WT, 16'h0104, 16'h1234, 1'b0);
        serve(C_IDEL, 16'h0, 16'h0, C_RD, 16'h0004, 16'h0, 1'b0);
        n_tests++;
        if (obs_rd !== 16'h1234) begin
            n_fail++;
            $display("FAIL alias_read got %h expected 1234", obs_rd);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        serve(C_WT, 16'h0040, 16'hAAAA, C_IDEL, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        memRW0 = C_WT; addrToMem0 = 16'h0040; dataToMem0 = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy got %b expected 1", busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        memRW0 = C_IDEL;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({dataFromMem0, dataFromMem1, addrFromMem0, addrFromMem1, memReadEn0, memReadEn1,
                 memWriteDone0, memWriteDone1, busy, havErr} !== 70'd0) begin
                n_fail++;
                $display("FAIL reset_mid_outputs busy=%b wd0=%b a0=%h expected all zero",
                         busy, memWriteDone0, addrFromMem0);
            end
            @(posedge clk);
        end
        #1 reset = 1'b0;
        ptr_m = 1'b0;
        err_m = 1'b0;
        serve(C_RD, 16'h0040, 16'h0, C_IDEL, 16'h0, 16'h0, 1'b0);
        n_tests++;
        if (obs_rd !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL reset_mid_discard got %h expected aaaa", obs_rd);
        end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1 memRW0 = C_ILL;
        @(posedge clk); #1 memRW0 = C_IDEL;
        err_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({havErr, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL illegal_sticky {err,busy} got %b expected 10", {havErr, busy});
            end
        end
        serve(C_RD, 16'h0012, 16'h0, C_IDEL, 16'h0, 16'h0, 1'b0);
        do_reset();
        @(negedge clk);
        n_tests++;
        if (havErr !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear got %b expected 0", havErr);
        end
    endtask

    task automatic test_random();
        logic [1:0]  rw [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        logic [1:0]  mask;
        for (int i = 0; i < 8; i++) begin
            serve(C_WT, {8'($urandom), 8'(8'h10 + i)}, 16'($urandom), C_IDEL, 16'h0, 16'h0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                rw[j] = mask[j] ? (($urandom_range(0, 1) == 0) ? C_RD : C_WT) : C_IDEL;
                a[j]  = {8'($urandom), 8'(8'h10 + $urandom_range(0, 7))};
                d[j]  = 16'($urandom);
            end
            serve(rw[0], a[0], d[0], rw[1], a[1], d[1], $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_both_rd();
        test_rd_vs_wt();
        test_alias();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
